// File: rtl/exec_result_stage.sv
// ----------------------------------------------------------------------------
// exec_result_stage
//
// Purpose:
//    Takes the parallel results of the ALU, picks the one named by the opcode,
//    and parks it in a two-entry FIFO until writeback consumes it. It also
//    keeps the architectural {N,Z,C,V} flags, flags reserved opcodes with a
//    one-cycle pulse, and counts retired (popped) entries.
//
// Ports:
//    clk, rst_n            rising-edge clock, asynchronous active-low reset
//    flush                 synchronous flush; empties the buffer
//    in_valid / in_ready   input handshake (in_ready = buffer not full)
//    opcode, rd_addr       operation and destination register
//    op1, op2              ALU operands (used for overflow)
//    *_res                 parallel ALU results, one per opcode
//    carry_add, carry_sub  carry-out of the add and subtract paths
//    out_valid / out_ready output handshake for the head entry
//    wb_data, wb_addr,     head entry; all zero while the buffer is empty
//    wb_en
//    flags                 {N,Z,C,V}, updated only on a push
//    illegal_op            one-cycle pulse after a reserved opcode is offered
//    retired               saturating count of popped entries
// ----------------------------------------------------------------------------
module exec_result_stage #(
   parameter int DEPTH = 2   // only 2 is supported
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  opcode,
   input  logic [2:0]  rd_addr,
   input  logic [15:0] op1,
   input  logic [15:0] op2,
   input  logic [15:0] add_res,
   input  logic [15:0] sub_res,
   input  logic [15:0] and_res,
   input  logic [15:0] or_res,
   input  logic [15:0] xor_res,
   input  logic [15:0] not_res,
   input  logic [15:0] cmp_res,
   input  logic        carry_add,
   input  logic        carry_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] wb_data,
   output logic [2:0]  wb_addr,
   output logic        wb_en,
   output logic [3:0]  flags,
   output logic        illegal_op,
   output logic [15:0] retired
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_CMP = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  addr;
      logic        wb_en;
   } entry_t;

   state_t      state_q, state_d;
   entry_t      entry_q [DEPTH];   // entry_q[0] is always the head
   entry_t      entry_d [DEPTH];
   logic [3:0]  flags_q, flags_d;
   logic        illegal_op_q, illegal_op_d;
   logic [15:0] retired_q, retired_d;

   logic        accept;
   logic        push;
   logic        pop;
   entry_t      new_entry;
   logic [15:0] result;
   logic        res_c;
   logic        res_v;
   logic [3:0]  new_flags;

   // -------------------------------------------------------------------------
   // Handshake qualification
   // -------------------------------------------------------------------------
   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign push      = accept & ~flush & (opcode != OP_RSV);
   assign pop       = out_valid & out_ready & ~flush;

   // -------------------------------------------------------------------------
   // Result selection and flag computation
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave it unassigned and infer a latch.
      result = '0;
      res_c  = 1'b0;
      res_v  = 1'b0;
      unique case (opcode)
         OP_ADD: begin
            result = add_res;
            res_c  = carry_add;
            res_v  = (op1[15] == op2[15]) & (add_res[15] != op1[15]);
         end
         OP_SUB: begin
            result = sub_res;
            res_c  = carry_sub;
            res_v  = (op1[15] != op2[15]) & (sub_res[15] != op1[15]);
         end
         OP_AND: result = and_res;
         OP_OR:  result = or_res;
         OP_XOR: result = xor_res;
         OP_NOT: result = not_res;
         OP_CMP: begin
            result = cmp_res;
            res_c  = carry_sub;
            res_v  = (op1[15] != op2[15]) & (cmp_res[15] != op1[15]);
         end
         default: ;   // reserved opcode never pushes
      endcase
      new_flags       = {result[15], (result == 16'h0000), res_c, res_v};
      new_entry.data  = result;
      new_entry.addr  = rd_addr;
      new_entry.wb_en = (opcode != OP_CMP);
   end

   // -------------------------------------------------------------------------
   // Buffer state machine and entry movement
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      if (flush) begin
         // Flush wins over any push or pop offered in the same cycle.
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  entry_d[0] = new_entry;
                  state_d    = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  // Head leaves and the newcomer takes its place.
                  entry_d[0] = new_entry;
               end else if (push) begin
                  entry_d[1] = new_entry;
                  state_d    = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  entry_d[0] = entry_q[1];
                  state_d    = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Flags, reserved-opcode pulse, retire counter
   // -------------------------------------------------------------------------
   always_comb begin
      flags_d      = push ? new_flags : flags_q;
      illegal_op_d = accept & (opcode == OP_RSV);
      retired_d    = retired_q;
      if (pop && (retired_q != 16'hFFFF)) begin
         retired_d = retired_q + 16'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   // NOTE: state is assigned with <= so every flop samples the values from
   // before this edge; blocking assignments here would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         flags_q      <= '0;
         illegal_op_q <= 1'b0;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         flags_q      <= flags_d;
         illegal_op_q <= illegal_op_d;
         retired_q    <= retired_d;
      end
   end

   // NOTE: the entry storage is deliberately not reset; the outputs below are
   // masked by out_valid, so stale contents are never visible.
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign wb_data    = out_valid ? entry_q[0].data  : 16'h0000;
   assign wb_addr    = out_valid ? entry_q[0].addr  : 3'b000;
   assign wb_en      = out_valid ? entry_q[0].wb_en : 1'b0;
   assign flags      = flags_q;
   assign illegal_op = illegal_op_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_exec_result_stage.sv
// ----------------------------------------------------------------------------
// tb_exec_result_stage
//
// Directed stimulus; every accepted push queues its expected head entry and a
// separate monitor compares whenever the DUT pops. Flags, handshakes, pulses
// and counters are checked directly at fixed points after clock edges.
// ----------------------------------------------------------------------------
module tb_exec_result_stage;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_CMP = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  opcode;
   logic [2:0]  rd_addr;
   logic [15:0] op1, op2;
   logic [15:0] add_res, sub_res, and_res, or_res, xor_res, not_res, cmp_res;
   logic        carry_add, carry_sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] wb_data;
   logic [2:0]  wb_addr;
   logic        wb_en;
   logic [3:0]  flags;
   logic        illegal_op;
   logic [15:0] retired;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  addr;
      logic        en;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   exec_result_stage #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .rd_addr    (rd_addr),
      .op1        (op1),
      .op2        (op2),
      .add_res    (add_res),
      .sub_res    (sub_res),
      .and_res    (and_res),
      .or_res     (or_res),
      .xor_res    (xor_res),
      .not_res    (not_res),
      .cmp_res    (cmp_res),
      .carry_add  (carry_add),
      .carry_sub  (carry_sub),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .wb_data    (wb_data),
      .wb_addr    (wb_addr),
      .wb_en      (wb_en),
      .flags      (flags),
      .illegal_op (illegal_op),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one operation; every unselected result carries a distinct junk value
   // so a wrong selection shows up in the data.
   task automatic set_op(input logic [2:0] op, input logic [2:0] rd,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic ca, input logic cs);
      in_valid  = 1'b1;
      opcode    = op;
      rd_addr   = rd;
      op1       = a;
      op2       = b;
      add_res   = 16'h1111;
      sub_res   = 16'h2222;
      and_res   = 16'h3333;
      or_res    = 16'h4444;
      xor_res   = 16'h5555;
      not_res   = 16'h6666;
      cmp_res   = 16'h7777;
      carry_add = ca;
      carry_sub = cs;
      case (op)
         OP_ADD: add_res = r;
         OP_SUB: sub_res = r;
         OP_AND: and_res = r;
         OP_OR:  or_res  = r;
         OP_XOR: xor_res = r;
         OP_NOT: not_res = r;
         OP_CMP: cmp_res = r;
         default: ;
      endcase
   endtask

   task automatic expect_entry(input logic [15:0] d, input logic [2:0] a, input logic en);
      exp_t e;
      e.data = d;
      e.addr = a;
      e.en   = en;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      opcode   = OP_ADD;
   endtask

   // Monitor: a pop happens at the next rising edge whenever these hold.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got data %h with nothing expected", wb_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pop_data", {16'h0, wb_data}, {16'h0, e.data});
            check("pop_addr", {29'h0, wb_addr}, {29'h0, e.addr});
            check("pop_wb_en", {31'h0, wb_en}, {31'h0, e.en});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      carry_add = 1'b0;
      carry_sub = 1'b0;
      op1 = '0; op2 = '0; rd_addr = '0;
      add_res = '0; sub_res = '0; and_res = '0; or_res = '0;
      xor_res = '0; not_res = '0; cmp_res = '0;
      idle();

      // ---- reset state ----
      #2;
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_flags", {28'h0, flags}, 32'h0);
      check("rst_retired", {16'h0, retired}, 32'h0);
      check("rst_wb_data", {16'h0, wb_data}, 32'h0);
      check("rst_illegal", {31'h0, illegal_op}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ---- ADD overflow ----
      out_ready = 1'b1;
      set_op(OP_ADD, 3'd3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0);
      expect_entry(16'h8000, 3'd3, 1'b1);
      step();
      idle();
      check("add_out_valid", {31'h0, out_valid}, 32'h1);
      check("add_wb_data", {16'h0, wb_data}, 32'h8000);
      check("add_wb_addr", {29'h0, wb_addr}, 32'h3);
      check("add_flags", {28'h0, flags}, 32'h9);
      step();
      check("add_drained", {31'h0, out_valid}, 32'h0);
      check("add_retired", {16'h0, retired}, 32'h1);

      // ---- CMP equal ----
      set_op(OP_CMP, 3'd5, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);
      expect_entry(16'h0000, 3'd5, 1'b0);
      step();
      idle();
      check("cmp_wb_en", {31'h0, wb_en}, 32'h0);
      check("cmp_flags", {28'h0, flags}, 32'h6);
      step();
      check("cmp_retired", {16'h0, retired}, 32'h2);

      // ---- back-to-back pushes with pop: state holds at ONE ----
      set_op(OP_SUB, 3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0);
      expect_entry(16'h7FFF, 3'd1, 1'b1);
      step();
      check("sub_flags", {28'h0, flags}, 32'h1);
      set_op(OP_OR, 3'd2, 16'hF000, 16'h0F00, 16'hFF00, 1'b1, 1'b1);
      expect_entry(16'hFF00, 3'd2, 1'b1);
      step();
      check("one_newhead", {16'h0, wb_data}, 32'hFF00);
      check("one_in_ready", {31'h0, in_ready}, 32'h1);
      check("or_flags", {28'h0, flags}, 32'h8);
      set_op(OP_NOT, 3'd4, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1);
      expect_entry(16'h0000, 3'd4, 1'b1);
      step();
      check("not_flags", {28'h0, flags}, 32'h4);
      set_op(OP_XOR, 3'd6, 16'h0F0F, 16'h0FF0, 16'h00FF, 1'b0, 1'b1);
      expect_entry(16'h00FF, 3'd6, 1'b1);
      step();
      check("xor_flags", {28'h0, flags}, 32'h0);
      idle();
      step();
      check("b2b_drained", {31'h0, out_valid}, 32'h0);
      check("b2b_retired", {16'h0, retired}, 32'h6);

      // ---- backpressure ----
      out_ready = 1'b0;
      set_op(OP_AND, 3'd1, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
      expect_entry(16'h0001, 3'd1, 1'b1);
      step();
      check("bp_ready_one", {31'h0, in_ready}, 32'h1);
      set_op(OP_AND, 3'd2, 16'hFFFF, 16'h0002, 16'h0002, 1'b0, 1'b0);
      expect_entry(16'h0002, 3'd2, 1'b1);
      step();
      check("bp_ready_full", {31'h0, in_ready}, 32'h0);
      set_op(OP_AND, 3'd3, 16'hFFFF, 16'h0003, 16'h0003, 1'b0, 1'b0);
      step();   // ignored: buffer is full
      idle();
      check("bp_hold_data", {16'h0, wb_data}, 32'h0001);
      check("bp_hold_addr", {29'h0, wb_addr}, 32'h1);
      step();
      check("bp_hold_data2", {16'h0, wb_data}, 32'h0001);
      out_ready = 1'b1;
      step();
      step();
      check("bp_drained", {31'h0, out_valid}, 32'h0);
      check("bp_retired", {16'h0, retired}, 32'h8);

      // ---- reserved opcode and flush ----
      out_ready = 1'b0;
      set_op(OP_ADD, 3'd3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0);
      expect_entry(16'h8000, 3'd3, 1'b1);
      step();
      set_op(OP_RSV, 3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
      step();
      check("rsv_illegal", {31'h0, illegal_op}, 32'h1);
      check("rsv_flags", {28'h0, flags}, 32'h9);
      check("rsv_no_push", {31'h0, in_ready}, 32'h1);
      set_op(OP_SUB, 3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1);
      expect_entry(16'hFFFF, 3'd2, 1'b1);
      step();
      idle();
      check("rsv_pulse_end", {31'h0, illegal_op}, 32'h0);
      check("sub2_flags", {28'h0, flags}, 32'hA);
      check("pre_flush_full", {31'h0, in_ready}, 32'h0);
      flush     = 1'b1;
      out_ready = 1'b1;   // flush must win over this pop
      sb.delete();
      step();
      flush     = 1'b0;
      out_ready = 1'b0;
      check("flush_out_valid", {31'h0, out_valid}, 32'h0);
      check("flush_wb_data", {16'h0, wb_data}, 32'h0);
      check("flush_flags", {28'h0, flags}, 32'hA);
      check("flush_retired", {16'h0, retired}, 32'h8);

      // ---- asynchronous reset while FULL ----
      set_op(OP_ADD, 3'd3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0);
      step();
      set_op(OP_OR, 3'd2, 16'hF000, 16'h0F00, 16'hFF00, 1'b1, 1'b1);
      step();
      idle();
      check("ar_full", {31'h0, in_ready}, 32'h0);
      check("ar_flags_before", {28'h0, flags}, 32'h8);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", {31'h0, out_valid}, 32'h0);
      check("ar_flags", {28'h0, flags}, 32'h0);
      check("ar_retired", {16'h0, retired}, 32'h0);
      check("ar_wb_data", {16'h0, wb_data}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      set_op(OP_CMP, 3'd4, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);
      expect_entry(16'hFFFF, 3'd4, 1'b0);
      step();
      idle();
      check("post_rst_valid", {31'h0, out_valid}, 32'h1);
      check("post_rst_flags", {28'h0, flags}, 32'h8);
      check("post_rst_wb_en", {31'h0, wb_en}, 32'h0);
      step();
      check("post_rst_retired", {16'h0, retired}, 32'h1);
      check("post_rst_empty", {31'h0, out_valid}, 32'h0);

      check("sb_empty", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
